fir_ctrl: RTL and testbench



---
 rtl/fir_ctrl_pkg.sv | 16 +
 rtl/fir_ctrl_result_buf.sv | 39 +++
 rtl/fir_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fir_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizing for the RNS FIR block sequencer.
package fir_ctrl_pkg;

    localparam int FIR_DATA_W   = 17;
    localparam int FIR_SAMPLES  = 10;
    localparam int FIR_PIPE_LAT = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } fir_ctrl_state_t;

endpackage

// File: rtl/fir_ctrl_result_buf.sv
// Result buffer: one synchronous write port, one registered read port.
// Reads past the last entry return zero.
module fir_ctrl_result_buf
    import fir_ctrl_pkg::*;
#(
    parameter int DEPTH  = FIR_SAMPLES,
    parameter int DATA_W = FIR_DATA_W,
    parameter int ADDR_W = 16,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; contents are only meaningful after a block completes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_addr < ADDR_W'(DEPTH)) begin
            rd_data <= mem[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/fir_ctrl.sv
// Block sequencer for the RNS FIR datapath: clear, stream SAMPLES words, capture results.
// Optional stall timeout in STREAM is enabled by defining FIR_CTRL_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// CLEAR  | one-cycle delay-line clear, counters and valid pipe zeroed
// STREAM | accepting samples from the source
// DRAIN  | all samples sent, waiting for the remaining results
// DONE   | block complete (or aborted by timeout), results readable
module fir_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_W   = FIR_DATA_W,
    parameter int SAMPLES  = FIR_SAMPLES,
    parameter int PIPE_LAT = FIR_PIPE_LAT,
    parameter int ADDR_W   = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              fir_clr,
    output logic              fir_en,
    output logic [DATA_W-1:0] fir_in,
    input  logic [DATA_W-1:0] fir_out,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int CNT_W = $clog2(SAMPLES + 1);
    localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    fir_ctrl_state_t state, state_next;
    logic [CNT_W-1:0]    acc_cnt, cap_cnt;
    logic [PIPE_LAT-1:0] vpipe;
    logic accept, capture, last_accept, last_capture, timeout_hit;

    assign accept       = src_valid && src_ready;
    assign last_accept  = accept && (acc_cnt == CNT_W'(SAMPLES - 1));
    // Captures outside STREAM/DRAIN are dropped, which discards in-flight results after an abort.
    assign capture      = vpipe[PIPE_LAT-1] && (state == S_STREAM || state == S_DRAIN)
                          && (cap_cnt < CNT_W'(SAMPLES));
    assign last_capture = capture && (cap_cnt == CNT_W'(SAMPLES - 1));

`ifdef FIR_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] stall_cnt;
    logic            err_q;

    assign timeout_hit = (state == S_STREAM) && !src_valid && (stall_cnt == TO_W'(TIMEOUT - 1));
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (reset || state == S_CLEAR) begin
            stall_cnt <= '0;
        end else if (state == S_STREAM) begin
            stall_cnt <= src_valid ? '0 : stall_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if (state == S_DONE && start) begin
            err_q <= 1'b0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        src_ready  = 1'b0;
        fir_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                busy       = 1'b1;
                fir_clr    = 1'b1;
                state_next = S_STREAM;
            end
            S_STREAM: begin
                busy      = 1'b1;
                src_ready = (acc_cnt < CNT_W'(SAMPLES));
                if (timeout_hit)      state_next = S_DONE;
                else if (last_accept) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (last_capture) state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_next = S_CLEAR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt <= '0;
            cap_cnt <= '0;
            vpipe   <= '0;
            fir_en  <= 1'b0;
            fir_in  <= '0;
        end else begin
            fir_en   <= accept;
            fir_in   <= accept ? src_data : '0;
            vpipe[0] <= fir_en;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            if (accept)  acc_cnt <= acc_cnt + CNT_W'(1);
            if (capture) cap_cnt <= cap_cnt + CNT_W'(1);
            if (state == S_CLEAR) begin
                acc_cnt <= '0;
                cap_cnt <= '0;
                vpipe   <= '0;
            end
        end
    end

    fir_ctrl_result_buf #(
        .DEPTH  (SAMPLES),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_idx  (cap_cnt[IDX_W-1:0]),
        .wr_data (fir_out),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl with an identity datapath delayed by PIPE_LAT cycles.
// Define FIR_CTRL_TIMEOUT_EN to also exercise the stall timeout (TIMEOUT=8).
module tb_fir_ctrl;

    localparam int DATA_W   = 17;
    localparam int SAMPLES  = 10;
    localparam int PIPE_LAT = 4;
    localparam int ADDR_W   = 16;

    logic              clk = 1'b0;
    logic              reset, start, src_valid;
    logic [DATA_W-1:0] src_data, fir_out;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy, done, err, src_ready, fir_clr, fir_en;
    logic [DATA_W-1:0] fir_in, rd_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DATA_W-1:0] fin_q[$];
    logic [DATA_W-1:0] res_q[$];
    logic [DATA_W-1:0] dp [PIPE_LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Identity datapath: fir_out at edge k+PIPE_LAT equals fir_in sampled at edge k.
    always @(posedge clk) begin
        dp[0] <= fir_in;
        for (int i = 1; i < PIPE_LAT; i++) dp[i] <= dp[i-1];
    end
    assign fir_out = dp[PIPE_LAT-1];

    fir_ctrl #(
        .DATA_W(DATA_W), .SAMPLES(SAMPLES), .PIPE_LAT(PIPE_LAT), .ADDR_W(ADDR_W), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .fir_clr(fir_clr), .fir_en(fir_en), .fir_in(fir_in), .fir_out(fir_out),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic read_word(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    // Starts a block, feeds samples base.. with an optional stall, returns edges from start to done.
    task automatic run_block(input int base, input int stall_after, input int stall_len,
                             input bit poke_start, output int done_rel, output int clr_cnt);
        int sent = 0;
        int stall = 0;
        int n0;
        logic [DATA_W-1:0] e;
        res_q.delete();
        fin_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n0 = cyc;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ack: done=%b busy=%b, required done=0 busy=1", done, busy);
        end
        clr_cnt  = fir_clr ? 1 : 0;
        done_rel = -1;
        for (int b = 0; b < 200 && done_rel < 0; b++) begin
            if (sent == stall_after && stall < stall_len) begin
                src_valid = 1'b0;
                stall++;
            end else if (sent < SAMPLES) begin
                src_valid = 1'b1;
                src_data  = DATA_W'(base + sent);
            end else begin
                src_valid = 1'b0;
            end
            start = poke_start && (sent == 3);
            #1;
            if (src_valid && src_ready) begin
                fin_q.push_back(src_data);
                res_q.push_back(src_data);
                sent++;
            end
            @(negedge clk);
            if (fir_clr) clr_cnt++;
            if (fir_en) begin
                e = (fin_q.size() > 0) ? fin_q.pop_front() : 'x;
                checks++;
                if (fir_in !== e) begin
                    errors++;
                    $display("FAIL fir_in: got %0d, required %0d", fir_in, e);
                end
            end
            if (done) done_rel = cyc - n0;
        end
        start     = 1'b0;
        src_valid = 1'b0;
        if (done_rel < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done never rose within 200 cycles");
        end
    endtask

    task automatic check_readback(input string tag);
        logic [DATA_W-1:0] d, e;
        for (int a = 0; a < SAMPLES; a++) begin
            read_word(ADDR_W'(a), d);
            e = (res_q.size() > 0) ? res_q.pop_front() : 'x;
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL %s rd[%0d]: got %0d, required %0d", tag, a, d, e);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, src_ready, fir_clr, fir_en} !== 6'b0 || fir_in !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b err=%b ready=%b clr=%b en=%b in=%0d rd=%0d, required all 0",
                     busy, done, err, src_ready, fir_clr, fir_en, fir_in, rd_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_block();
        int rel, clr;
        run_block(1, -1, 0, 1'b0, rel, clr);
        checks++;
        if (rel != SAMPLES + PIPE_LAT + 2) begin
            errors++;
            $display("FAIL basic_done_edge: got %0d, required %0d", rel, SAMPLES + PIPE_LAT + 2);
        end
        checks++;
        if (clr != 1) begin
            errors++;
            $display("FAIL fir_clr_width: got %0d cycles, required 1", clr);
        end
        checks++;
        if (busy !== 1'b0 || src_ready !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL done_outputs: busy=%b ready=%b err=%b, required 0 0 0", busy, src_ready, err);
        end
        check_readback("basic");
    endtask

    task automatic test_stall();
        int rel, clr;
        run_block(21, 5, 3, 1'b0, rel, clr);
        checks++;
        if (rel != SAMPLES + PIPE_LAT + 5) begin
            errors++;
            $display("FAIL stall_done_edge: got %0d, required %0d", rel, SAMPLES + PIPE_LAT + 5);
        end
        check_readback("stall");
    endtask

    task automatic test_back_to_back();
        int rel, clr;
        run_block(41, -1, 0, 1'b1, rel, clr);
        checks++;
        if (rel != SAMPLES + PIPE_LAT + 2) begin
            errors++;
            $display("FAIL start_ignored_edge: got %0d, required %0d", rel, SAMPLES + PIPE_LAT + 2);
        end
        run_block(101, -1, 0, 1'b0, rel, clr);
        checks++;
        if (rel != SAMPLES + PIPE_LAT + 2) begin
            errors++;
            $display("FAIL second_block_edge: got %0d, required %0d", rel, SAMPLES + PIPE_LAT + 2);
        end
        check_readback("overwrite");
    endtask

    task automatic test_reset_mid();
        int rel, clr;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        src_valid = 1'b1;
        for (int k = 0; k < 14; k++) begin
            src_data = DATA_W'(50 + k);
            @(negedge clk);
        end
        src_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL drain_state: busy=%b done=%b, required 1 0", busy, done);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, src_ready, fir_clr, fir_en} !== 6'b0 || fir_in !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_values: busy=%b done=%b err=%b ready=%b clr=%b en=%b in=%0d rd=%0d, required all 0",
                     busy, done, err, src_ready, fir_clr, fir_en, fir_in, rd_data);
        end
        reset = 1'b0;
        run_block(201, -1, 0, 1'b0, rel, clr);
        checks++;
        if (rel != SAMPLES + PIPE_LAT + 2) begin
            errors++;
            $display("FAIL after_reset_edge: got %0d, required %0d", rel, SAMPLES + PIPE_LAT + 2);
        end
        check_readback("after_reset");
    endtask

    task automatic test_oob_read();
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] addrs [3];
        logic [DATA_W-1:0] exp_d [3];
        addrs = '{ADDR_W'(SAMPLES), ADDR_W'(16'hFFFF), ADDR_W'(SAMPLES - 1)};
        exp_d = '{'0, '0, DATA_W'(210)};
        for (int i = 0; i < 3; i++) begin
            read_word(addrs[i], d);
            checks++;
            if (d !== exp_d[i]) begin
                errors++;
                $display("FAIL oob_read[%0h]: got %0d, required %0d", addrs[i], d, exp_d[i]);
            end
        end
    endtask

`ifdef FIR_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int rel, clr;
        run_block(301, 4, 1000, 1'b0, rel, clr);
        checks++;
        if (rel != 4 + 1 + 8 || done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout: edge=%0d done=%b err=%b, required edge 13 done=1 err=1", rel, done, err);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: done=%b err=%b, required 0 0", done, err);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_block();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_oob_read();
`ifdef FIR_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
